// File: rtl/arb_hs_rr.sv
// arb_hs_rr: round-robin sharing of one 4-phase downstream channel among N requesters.
// Build option ARB_HS_SYNC_EN inserts 2-flop synchronizers on r_i and a_o.
module arb_hs_rr #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] r_i,
  output logic [N-1:0] a_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] gnt,
  output logic         busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [PW:0]  NX  = (PW+1)'(N);
  localparam logic [PW:0]  INC = (PW+1)'(1);
  localparam logic [N-1:0] ONE = N'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_RTZ  = 2'd3;

  logic [N-1:0]  r_s;
  logic          a_s;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g;

  logic          win_vld;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;

  logic [PW:0]   g_inc;
  logic [PW-1:0] ptr_nxt;

`ifdef ARB_HS_SYNC_EN
  logic [N-1:0] r_m;
  logic         a_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m <= '0;
      r_s <= '0;
      a_m <= 1'b0;
      a_s <= 1'b0;
    end else begin
      r_m <= r_i;
      r_s <= r_m;
      a_m <= a_o;
      a_s <= a_m;
    end
  end
`else
  assign r_s = r_i;
  assign a_s = a_o;
`endif

  // Walk downward so the candidate closest to ptr is the last to win.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= NX) begin
        cand = cand - NX;
      end
      if (r_s[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  assign g_inc   = {1'b0, g} + INC;
  assign ptr_nxt = (g_inc == NX) ? '0 : g_inc[PW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      g     <= '0;
      gnt   <= '0;
      a_i   <= '0;
      r_o   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_vld) begin
            g     <= win_idx;
            gnt   <= ONE << win_idx;
            r_o   <= 1'b1;
            busy  <= 1'b1;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (a_s) begin
            a_i   <= gnt;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!r_s[g]) begin
            r_o   <= 1'b0;
            state <= S_RTZ;
          end
        end
        S_RTZ: begin
          if (!a_s) begin
            a_i   <= '0;
            gnt   <= '0;
            ptr   <= ptr_nxt;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_hs_rr.sv
// tb_arb_hs_rr: directed and randomized 4-phase transactions for arb_hs_rr.
// Expected outputs come from a round-robin model over request vectors.
module tb_arb_hs_rr;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] r_i;
  logic [N-1:0] a_i;
  logic         r_o;
  logic         a_o;
  logic [N-1:0] gnt;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int mp       = 0;
  int g;

  arb_hs_rr #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .r_i  (r_i),
    .a_i  (a_i),
    .r_o  (r_o),
    .a_o  (a_o),
    .gnt  (gnt),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] snap();
    return {busy, r_o, a_i, gnt};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs,
                     input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First requester at or after p, wrapping modulo N.
  function automatic int rr_pick(input logic [N-1:0] req, input int p);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (p + k) % N;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic jitter(input logic [N-1:0] oh, input bit en);
    if (en) r_i = (r_i & oh) | (4'($urandom) & ~oh);
  endtask

  task automatic txn(input logic [N-1:0] req, input int d1, input int d2,
                     input int d3, input bit early, input bit noise,
                     output int gw);
    logic [N-1:0] oh;
    gw  = rr_pick(req, mp);
    oh  = 4'b0001 << gw;
    r_i = req;
    a_o = 1'b0;
    step();
    chk("grant", snap(), {2'b11, 4'b0000, oh});
    if (early) r_i = r_i & ~oh;
    for (int i = 0; i < d1; i++) begin
      jitter(oh, noise);
      step();
      chk("req_hold", snap(), {2'b11, 4'b0000, oh});
    end
    a_o = 1'b1;
    step();
    chk("ack", snap(), {2'b11, oh, oh});
    for (int i = 0; i < (early ? 0 : d2); i++) begin
      jitter(oh, noise);
      step();
      chk("ack_hold", snap(), {2'b11, oh, oh});
    end
    r_i = r_i & ~oh;
    step();
    chk("rtz", snap(), {2'b10, oh, oh});
    for (int i = 0; i < d3; i++) begin
      jitter(oh, noise);
      step();
      chk("rtz_hold", snap(), {2'b10, oh, oh});
    end
    a_o = 1'b0;
    step();
    chk("idle", snap(), 10'b0);
    mp = (gw + 1) % N;
  endtask

  initial begin
    rst = 1'b1;
    r_i = '0;
    a_o = 1'b0;
    #1;
    chk("reset", snap(), 10'b0);
    step();
    step();
    rst = 1'b0;
    mp  = 0;

    // single requester, immediate responses
    txn(4'b0001, 0, 0, 0, 1'b0, 1'b0, g);
    chk("single_g0", 10'(g), 10'd0);

    r_i = 4'b0000;
    step();
    chk("idle_noreq", snap(), 10'b0);

    // all requesting: strict rotation
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 0, 0, 0, 1'b0, 1'b0, g);
      chk("rr_order", 10'(g), 10'((i + 1) % N));
    end

    // reset mid-transaction in ACK
    r_i = 4'b0010;
    a_o = 1'b0;
    step();
    a_o = 1'b1;
    step();
    chk("pre_rst_ack", snap(), {2'b11, 4'b0010, 4'b0010});
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", snap(), 10'b0);
    r_i = 4'b0000;
    a_o = 1'b0;
    step();
    rst = 1'b0;
    mp  = 0;
    txn(4'b1111, 0, 0, 0, 1'b0, 1'b0, g);
    chk("rst_ptr0", 10'(g), 10'd0);

    // pointer at 3 with requesters 0 and 3
    txn(4'b0100, 1, 1, 1, 1'b0, 1'b1, g);
    txn(4'b1001, 0, 0, 0, 1'b0, 1'b0, g);
    chk("wrap_g3", 10'(g), 10'd3);
    txn(4'b1001, 0, 0, 0, 1'b0, 1'b0, g);
    chk("wrap_g0", 10'(g), 10'd0);

    // early drop of the granted request while waiting for a_o
    txn(4'b0100, 2, 0, 1, 1'b1, 1'b0, g);

    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] req;
      bit           early;
      req   = 4'($urandom_range(1, 15));
      early = ($urandom_range(0, 3) == 0);
      txn(req, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), early, 1'($urandom), g);
      if ($urandom_range(0, 4) == 0) begin
        r_i = '0;
        step();
        chk("idle_gap", snap(), 10'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
